pwm_from_count: RTL and testbench

- Downstream consumer of the free-running 4-bit up counter (clk/rstn/out[3:0]).
- Turns the sampled count into a registered PWM waveform. Duty is loaded through a valid/ready handshake and applied only at period boundaries, so every period has a clean, glitch-free duty.
- Also flags period starts, counts wraps, and detects illegal count sequences, so the counter's health is visible to software and to the bench.

---
 rtl/pwm_from_count.sv | 159 +++++++++++++++
 tb/tb_pwm_from_count.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_from_count.sv
// ---------------------------------------------------------------------------
// PwmFromCount (module pwm_from_count)
//
// Turns the count from an upstream free-running up counter into a registered
// PWM waveform. A new duty is accepted through a valid/ready handshake into a
// single pending slot and only takes effect at a period boundary, so no
// period ever sees a duty change part-way through. The block also reports
// period starts, counts MAX->0 wraps (saturating) and keeps a sticky flag for
// count sequences the upstream counter should never produce.
//
// Ports:
//   clk          in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   cnt          in   [WIDTH-1:0] upstream count, sampled every clk
//   duty_in      in   [WIDTH:0]   requested high cycles per period
//   duty_valid   in   duty_in is valid
//   duty_ready   out  pending slot is empty, a new duty can be accepted
//   err_clr      in   clears seq_err (a same-cycle new error wins)
//   pwm_out      out  registered PWM output
//   period_start out  one-cycle pulse after a wrap or restart is seen
//   wrap_count   out  [WRAPW-1:0] saturating count of MAX->0 wraps
//   seq_err      out  sticky illegal-sequence flag
// ---------------------------------------------------------------------------
module pwm_from_count #(
  parameter int WIDTH = 4,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH:0]   duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic             err_clr,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WRAPW-1:0] wrap_count,
  output logic             seq_err
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   DUTY_MAX = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WRAPW-1:0] WRAP_MAX = '1;
  localparam logic [WRAPW-1:0] WRAP_ONE = WRAPW'(1);

  logic             r_primed;
  logic [WIDTH-1:0] r_cnt_q;
  logic [WIDTH:0]   r_active;
  logic [WIDTH:0]   r_pending;
  logic             r_pend_full;
  logic             r_pwm;
  logic             r_pstart;
  logic [WRAPW-1:0] r_wrap_cnt;
  logic             r_seq_err;

  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_hold;
  logic             w_advance;
  logic             w_wrap;
  logic             w_restart;
  logic             w_legal;
  logic             w_pstart;
  logic             w_err;
  logic             w_accept;
  logic [WIDTH:0]   w_duty_clamped;
  logic [WIDTH:0]   w_duty_eff;

  // Classify the step from the previous sample to the current one. A return
  // to zero from anywhere other than 0 or MAX is the upstream counter being
  // reset mid-count, which is legal and restarts the period.
  assign w_cnt_inc = r_cnt_q + CNT_ONE;
  assign w_hold    = (cnt == r_cnt_q);
  assign w_advance = (cnt == w_cnt_inc) && (r_cnt_q != CNT_MAX);
  assign w_wrap    = (r_cnt_q == CNT_MAX) && (cnt == CNT_ZERO);
  assign w_restart = (cnt == CNT_ZERO) && (r_cnt_q != CNT_ZERO) && (r_cnt_q != CNT_MAX);
  assign w_legal   = w_hold || w_advance || w_wrap || w_restart;

  // Nothing is classified until one sample has been captured after reset.
  assign w_pstart  = r_primed && (w_wrap || w_restart);
  assign w_err     = r_primed && !w_legal;

  assign duty_ready     = !r_pend_full;
  assign w_accept       = duty_valid && duty_ready;
  assign w_duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

  // The compare on a period-start clk must already use the duty that period
  // will run with, otherwise the first cycle of each period would glitch.
  assign w_duty_eff = (w_pstart && r_pend_full) ? r_pending : r_active;

  assign pwm_out      = r_pwm;
  assign period_start = r_pstart;
  assign wrap_count   = r_wrap_cnt;
  assign seq_err      = r_seq_err;

  // Sample tracking: remember the last count and note that a reference
  // sample exists so the next clk can be classified.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_primed <= 1'b0;
      r_cnt_q  <= '0;
    end else begin
      r_primed <= 1'b1;
      r_cnt_q  <= cnt;
    end
  end

  // Duty handshake and application. An accept can only happen while the
  // slot is empty, so it never collides with a period start consuming the
  // slot; an accept on a period-start clk simply waits for the next period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pending   <= w_duty_clamped;
      r_pend_full <= 1'b1;
    end else if (w_pstart && r_pend_full) begin
      r_active    <= r_pending;
      r_pend_full <= 1'b0;
    end
  end

  // PWM and period-start outputs are registered so they are glitch free.
  // The compare is widened by one bit so a full-period duty yields a
  // constant high level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pwm    <= 1'b0;
      r_pstart <= 1'b0;
    end else begin
      r_pwm    <= r_primed && ({1'b0, cnt} < w_duty_eff);
      r_pstart <= w_pstart;
    end
  end

  // Saturating wrap counter; restarts do not count as wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrap_cnt <= '0;
    end else if (r_primed && w_wrap && (r_wrap_cnt != WRAP_MAX)) begin
      r_wrap_cnt <= r_wrap_cnt + WRAP_ONE;
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seq_err <= 1'b0;
    end else if (w_err) begin
      r_seq_err <= 1'b1;
    end else if (err_clr) begin
      r_seq_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_from_count.sv
// ---------------------------------------------------------------------------
// TbPwmFromCount (module tb_pwm_from_count)
//
// Directed bench for pwm_from_count. Each stimulus cycle states by hand what
// kind of count step it is (plain, wrap, restart, illegal) and the expected
// outputs after that edge are pushed into a queue; a monitor pops one entry
// per falling edge and compares it against the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_from_count;

  localparam int KIND_NORMAL  = 0;
  localparam int KIND_WRAP    = 1;
  localparam int KIND_RESTART = 2;
  localparam int KIND_ERROR   = 3;

  typedef struct packed {
    logic       pwm;
    logic       ps;
    logic       rdy;
    logic [7:0] wr;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [3:0] cnt;
  logic [4:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       err_clr;
  logic       pwm_out;
  logic       period_start;
  logic [7:0] wrap_count;
  logic       seq_err;

  int   checks   = 0;
  int   failures = 0;
  int   cycleNo  = 0;
  exp_t sbQueue[$];

  // Hand-maintained expectation state, updated by the directed sequence.
  int   expDuty     = 0;
  int   expPendVal  = 0;
  bit   expPendFull = 0;
  bit   expReady    = 1;
  int   expWraps    = 0;
  bit   expErr      = 0;
  bit   expPrimed   = 0;

  pwm_from_count #(.WIDTH(4), .WRAPW(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cnt          (cnt),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .err_clr      (err_clr),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .wrap_count   (wrap_count),
    .seq_err      (seq_err)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d required=%0d", name, cycleNo, actual, expected);
    end
  endfunction

  // Scoreboard monitor: one expectation per stimulus edge, checked mid-cycle.
  always @(negedge clk) begin
    if (rstn && sbQueue.size() > 0) begin
      exp_t e;
      e = sbQueue.pop_front();
      cycleNo++;
      checkOutput("pwm_out",      {31'd0, pwm_out},      {31'd0, e.pwm});
      checkOutput("period_start", {31'd0, period_start}, {31'd0, e.ps});
      checkOutput("duty_ready",   {31'd0, duty_ready},   {31'd0, e.rdy});
      checkOutput("wrap_count",   {24'd0, wrap_count},   {24'd0, e.wr});
      checkOutput("seq_err",      {31'd0, seq_err},      {31'd0, e.err});
    end
  end

  // Drive one clk worth of inputs and queue what the DUT must show after it.
  task automatic applyStimulus(input logic [3:0] c, input logic dv, input logic [4:0] din,
                               input logic ec, input int kind);
    exp_t e;
    bit   canAccept;
    canAccept = !expPendFull;
    if (kind == KIND_WRAP && expWraps < 255) expWraps++;
    if ((kind == KIND_WRAP || kind == KIND_RESTART) && expPendFull) begin
      expDuty     = expPendVal;
      expPendFull = 0;
      expReady    = 1;
    end
    if (kind == KIND_ERROR) expErr = 1;
    else if (ec) expErr = 0;
    e.pwm = expPrimed && (int'(c) < expDuty);
    if (dv && canAccept) begin
      expPendVal  = (din > 5'd16) ? 16 : int'(din);
      expPendFull = 1;
      expReady    = 0;
    end
    e.ps  = (kind == KIND_WRAP) || (kind == KIND_RESTART);
    e.rdy = expReady;
    e.wr  = 8'(expWraps);
    e.err = expErr;
    cnt        = c;
    duty_valid = dv;
    duty_in    = din;
    err_clr    = ec;
    @(posedge clk);
    #1;
    sbQueue.push_back(e);
    duty_valid = 1'b0;
    err_clr    = 1'b0;
    expPrimed  = 1;
  endtask

  task automatic runCount(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(4'(i), 1'b0, 5'd0, 1'b0, KIND_NORMAL);
  endtask

  task automatic wrapPeriod();
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_WRAP);
    runCount(1, 15);
  endtask

  // Full period that also offers a new duty at cnt=7.
  task automatic loadPeriod(input logic [4:0] d);
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_WRAP);
    runCount(1, 6);
    applyStimulus(4'd7, 1'b1, d, 1'b0, KIND_NORMAL);
    runCount(8, 15);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pwm"},   {31'd0, pwm_out},      32'd0);
    checkOutput({tag, "_ps"},    {31'd0, period_start}, 32'd0);
    checkOutput({tag, "_wrap"},  {24'd0, wrap_count},   32'd0);
    checkOutput({tag, "_err"},   {31'd0, seq_err},      32'd0);
    checkOutput({tag, "_ready"}, {31'd0, duty_ready},   32'd1);
  endtask

  initial begin
    rstn       = 1'b0;
    cnt        = 4'd0;
    duty_in    = 5'd0;
    duty_valid = 1'b0;
    err_clr    = 1'b0;
    #12;
    checkResetState("reset");
    rstn = 1'b1;

    // Priming edge, then first period with duty 5 loaded mid-period.
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_NORMAL);
    runCount(1, 6);
    applyStimulus(4'd7, 1'b1, 5'd5, 1'b0, KIND_NORMAL);
    runCount(8, 15);
    repeat (2) wrapPeriod();

    // Boundary duties: 0 for three periods, then 31 clamped to 16.
    loadPeriod(5'd0);
    repeat (3) wrapPeriod();
    loadPeriod(5'd31);
    repeat (3) wrapPeriod();

    // Upstream restart at cnt=9 held for three cycles, duty 8 pending.
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_WRAP);
    runCount(1, 2);
    applyStimulus(4'd3, 1'b1, 5'd8, 1'b0, KIND_NORMAL);
    runCount(4, 9);
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_RESTART);
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_NORMAL);
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_NORMAL);
    runCount(1, 15);

    // Accept on the wrap clk: old duty this period, new duty from the next.
    applyStimulus(4'd0, 1'b1, 5'd3, 1'b0, KIND_WRAP);
    runCount(1, 15);
    wrapPeriod();

    // Illegal jump 3->7, sticky through a period, clear, then clear+error.
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_WRAP);
    runCount(1, 3);
    applyStimulus(4'd7, 1'b0, 5'd0, 1'b0, KIND_ERROR);
    runCount(8, 15);
    wrapPeriod();
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_WRAP);
    runCount(1, 4);
    applyStimulus(4'd5, 1'b0, 5'd0, 1'b1, KIND_NORMAL);
    runCount(6, 7);
    applyStimulus(4'd2, 1'b0, 5'd0, 1'b1, KIND_ERROR);
    runCount(3, 15);

    // Asynchronous reset between edges mid-period.
    applyStimulus(4'd0, 1'b0, 5'd0, 1'b0, KIND_WRAP);
    runCount(1, 6);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkResetState("asyncReset");
    expDuty = 0; expPendVal = 0; expPendFull = 0; expReady = 1;
    expWraps = 0; expErr = 0; expPrimed = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    applyStimulus(4'd6, 1'b0, 5'd0, 1'b0, KIND_NORMAL);
    runCount(7, 15);

    // Long run to saturate the wrap counter.
    loadPeriod(5'd10);
    repeat (300) wrapPeriod();

    repeat (2) @(negedge clk);
    #1;
    checkOutput("queueDrained", sbQueue.size(), 32'd0);
    checkOutput("wrapSaturated", {24'd0, wrap_count}, 32'd255);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
